// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the 4-bit adder BIST controller.
// Maps a sweep index onto the interleaved {cin,a,b} operand vector.
package adder_bist_pkg;

  localparam int VEC_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // Sweep bits are interleaved b0,a0,b1,a1,... from the LSB so that low-order
  // carry chains are exercised early in the sweep.
  function automatic logic [VEC_W-1:0] k_to_vec(input logic [VEC_W-1:0] k,
                                                input logic             sweep_cin);
    logic [3:0] a;
    logic [3:0] b;
    for (int i = 0; i < 4; i++) begin
      a[i] = k[2*i+1];
      b[i] = k[2*i];
    end
    return {sweep_cin & k[8], a, b};
  endfunction

endpackage

// File: rtl/adder_bist_golden.sv
// Combinational reference adder: 5-bit {cout,s} = a + b + cin.
module adder_bist_golden (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST controller for a 4-bit adder: exhaustive operand sweep, settle window,
// golden comparison, saturating error count and first-failing-index capture.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          SWEEP_CIN     = 1'b0,
  parameter int unsigned ERR_W         = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [3:0]       a,
  output logic [3:0]       b,
  output logic             cin,
  input  logic [3:0]       s,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] fail_k
);

  localparam logic [VEC_W-1:0] LAST_K      = SWEEP_CIN ? VEC_W'(511) : VEC_W'(255);
  localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  state_t           state;
  logic [VEC_W-1:0] k;
  logic [3:0]       settle_cnt;
  logic [4:0]       golden_sum;
  logic [VEC_W-1:0] vec;
  logic             mismatch;
  logic             err_sat;

  adder_bist_golden u_golden (
    .a   (a),
    .b   (b),
    .cin (cin),
    .sum (golden_sum)
  );

  assign vec      = k_to_vec(k, SWEEP_CIN);
  assign mismatch = ({cout, s} != golden_sum);
  assign err_sat  = &err_cnt;

  // NOTE: all state lives in this one block with non-blocking assignments, so
  // every register samples pre-edge values (e.g. err_cnt==0 for first-fail capture).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      settle_cnt <= '0;
      a          <= '0;
      b          <= '0;
      cin        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_k     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= DRIVE;
            k       <= '0;
            err_cnt <= '0;
            fail_k  <= '0;
            pass    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        DRIVE: begin
          {cin, a, b} <= vec;
          if (SETTLE_CYCLES == 0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) state <= CHECK;
          else                    settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            if (!err_sat)          err_cnt <= err_cnt + ERR_ONE;
            if (err_cnt == '0)     fail_k  <= k;
          end
          if (k == LAST_K) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_cnt == '0);
          end else begin
            k     <= k + VEC_W'(1);
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
